spy_path_prober: RTL

// Launch/capture controller for the inverting spy delay chains (singlepath_*_spy_* chained N times).
// - Drives the chain input with a clean edge.
// - Synchronises the chain output and counts clock cycles until the expected level arrives.
// - Reports the delay, or a timeout.
// - Sits between the chain instance and the host/readout logic. One prober drives one chain.

---
 rtl/spy_path_prober.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spy_path_prober.sv
// Launch/capture controller for an inverting spy delay chain: drives a clean edge, times its return.
// Optional SPY_PROBE_ACCUM_EN: back-to-back trials with a running delay sum (trials/acc_sum ports).
module spy_path_prober #(
   parameter int CNT_W         = 16,
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 8,
   parameter int INVERTING     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] timeout_cycles,
   output logic             path_launch,
   input  logic             path_result,
   output logic             busy,
   output logic             done,
   output logic             timed_out,
   output logic [CNT_W-1:0] delay_cycles
`ifdef SPY_PROBE_ACCUM_EN
   ,
   input  logic [7:0]       trials,
   output logic [CNT_W+7:0] acc_sum
`endif
);

   localparam int SCW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
   localparam logic INV = (INVERTING != 0);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      LAUNCH,
      WAIT
   } state_t;

   state_t               r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [SCW-1:0]       r_settle;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     r_tmo;
   logic                 w_sync;
   logic                 w_match;
   logic                 w_more;

   assign w_sync  = r_sync[SYNC_STAGES-1];
   assign w_match = (w_sync == (path_launch ^ INV));

`ifdef SPY_PROBE_ACCUM_EN
   logic [7:0] r_trials;
   assign w_more = (r_trials > 8'd1);
`else
   assign w_more = 1'b0;
`endif

   // path_result is asynchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], path_result};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_settle     <= '0;
         r_cnt        <= '0;
         r_tmo        <= '0;
         path_launch  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timed_out    <= 1'b0;
         delay_cycles <= '0;
`ifdef SPY_PROBE_ACCUM_EN
         r_trials     <= 8'd0;
         acc_sum      <= '0;
`endif
      end else begin
         done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_tmo        <= (timeout_cycles == '0) ? '1 : timeout_cycles;
                  timed_out    <= 1'b0;
                  delay_cycles <= '0;
                  busy         <= 1'b1;
                  r_settle     <= '0;
                  r_state      <= SETTLE;
`ifdef SPY_PROBE_ACCUM_EN
                  r_trials     <= (trials == 8'd0) ? 8'd1 : trials;
                  acc_sum      <= '0;
`endif
               end
            end
            SETTLE: begin
               if (r_settle == SETTLE_LAST) begin
                  r_state <= LAUNCH;
               end else begin
                  r_settle <= r_settle + 1'b1;
               end
            end
            LAUNCH: begin
               path_launch <= ~path_launch;
               r_cnt       <= CNT_W'(1);
               r_state     <= WAIT;
            end
            WAIT: begin
               // a match wins over a timeout landing on the same edge
               if (w_match || (r_cnt == r_tmo)) begin
                  delay_cycles <= r_cnt;
`ifdef SPY_PROBE_ACCUM_EN
                  acc_sum      <= acc_sum + {8'd0, r_cnt};
`endif
                  if (w_match && w_more) begin
`ifdef SPY_PROBE_ACCUM_EN
                     r_trials <= r_trials - 8'd1;
`endif
                     r_settle <= '0;
                     r_state  <= SETTLE;
                  end else begin
                     timed_out <= ~w_match;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     r_state   <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
